// File: rtl/serial_reduce_ctrl_if.sv
// Request/result handshake bundle for serial_reduce_ctrl.
// Requester/consumer side uses the master modport; the controller uses slave.
interface serial_reduce_ctrl_if #(
  parameter int W = 20,
  parameter int C = 4
);
  localparam int NCHUNK = (W + C - 1) / C;
  localparam int CYW    = $clog2(NCHUNK + 1);

  logic           i_valid;
  logic           o_ready;
  logic [2:0]     i_op;
  logic [W-1:0]   i_data;
  logic           o_valid;
  logic           i_ready;
  logic           o_result;
  logic [CYW-1:0] o_cycles;

  modport master (
    output i_valid, i_op, i_data, i_ready,
    input  o_ready, o_valid, o_result, o_cycles
  );

  modport slave (
    input  i_valid, i_op, i_data, i_ready,
    output o_ready, o_valid, o_result, o_cycles
  );
endinterface

// File: rtl/serial_reduce_ctrl.sv
// serial_reduce_ctrl: walks a W-bit operand C bits per cycle through a single
// reduction slice (AND/OR/XOR/XNOR/BOOL/NOT) and returns a 1-bit result.
// Optional macro SERIAL_REDUCE_EARLY_EXIT_EN: stop as soon as an AND-class
// chunk reduces to 0 or an OR-class chunk reduces to 1.
//
// state | meaning
// IDLE  | ready for a request (o_ready=1)
// RUN   | consuming one chunk per cycle, LSB chunk first
// DONE  | result presented (o_valid=1) until the consumer takes it
module serial_reduce_ctrl #(
  parameter int W = 20,
  parameter int C = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  serial_reduce_ctrl_if.slave  bus
);
  localparam int NCHUNK = (W + C - 1) / C;
  localparam int SW     = NCHUNK * C;
  localparam int CYW    = $clog2(NCHUNK + 1);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_XNOR = 3'd3;
  localparam logic [2:0] OP_BOOL = 3'd4;
  localparam logic [2:0] OP_NOT  = 3'd5;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [SW-1:0]  shift_q;
  logic [2:0]     op_q;
  logic           acc_q;
  logic [CYW-1:0] count_q;
  logic           result_q;
  logic [CYW-1:0] cycles_q;

  logic           accept;
  logic           ident;
  logic [SW-1:0]  load_val;
  logic [C-1:0]   chunk;
  logic           is_and, is_or, is_xor;
  logic           red_bit;
  logic           acc_nxt;
  logic [CYW-1:0] count_nxt;
  logic           last_chunk;
  logic           early_exit;
  logic           finish;
  logic           final_result;

  assign accept = bus.i_valid && (state == IDLE);

  // Operand load value: unused high bits of the last chunk carry the identity
  // so they never change the reduction.
  always_comb begin
    ident    = (bus.i_op == OP_AND);
    load_val = {SW{ident}};
    load_val[W-1:0] = bus.i_data;
  end

  // Chunk reduction, accumulate, and termination decode for the RUN cycle.
  always_comb begin
    chunk      = shift_q[C-1:0];
    is_and     = (op_q == OP_AND);
    is_or      = (op_q == OP_OR) || (op_q == OP_BOOL) || (op_q == OP_NOT);
    is_xor     = (op_q == OP_XOR) || (op_q == OP_XNOR);
    red_bit    = is_and ? (&chunk) : (is_xor ? (^chunk) : (|chunk));
    acc_nxt    = is_and ? (acc_q & red_bit) : (is_xor ? (acc_q ^ red_bit) : (acc_q | red_bit));
    count_nxt  = count_q + CYW'(1);
    last_chunk = (count_q == CYW'(NCHUNK - 1));
`ifdef SERIAL_REDUCE_EARLY_EXIT_EN
    early_exit = (is_and && !red_bit) || (is_or && red_bit);
`else
    early_exit = 1'b0;
`endif
    finish     = last_chunk || early_exit;
    case (op_q)
      OP_AND, OP_OR, OP_XOR, OP_BOOL: final_result = acc_nxt;
      OP_XNOR, OP_NOT:                final_result = ~acc_nxt;
      default:                        final_result = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_valid) state_nxt = RUN;
      RUN:     if (finish)      state_nxt = DONE;
      DONE:    if (bus.i_ready) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Datapath: latch request on accept, step one chunk per RUN cycle,
  // capture result and cycle count on the final chunk.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_q  <= '0;
      op_q     <= '0;
      acc_q    <= 1'b0;
      count_q  <= '0;
      result_q <= 1'b0;
      cycles_q <= '0;
    end else if (accept) begin
      shift_q  <= load_val;
      op_q     <= bus.i_op;
      acc_q    <= ident;
      count_q  <= '0;
    end else if (state == RUN) begin
      shift_q  <= shift_q >> C;
      acc_q    <= acc_nxt;
      count_q  <= count_nxt;
      if (finish) begin
        result_q <= final_result;
        cycles_q <= count_nxt;
      end
    end
  end

  assign bus.o_ready  = (state == IDLE);
  assign bus.o_valid  = (state == DONE);
  assign bus.o_result = result_q;
  assign bus.o_cycles = cycles_q;
endmodule

// File: tb/tb_serial_reduce_ctrl.sv
// Directed bench for serial_reduce_ctrl: table of vectors on a W=20/C=4
// instance, a W=20/C=6 instance for padding, plus DONE-hold and mid-RUN reset.
module tb_serial_reduce_ctrl;
`ifdef SERIAL_REDUCE_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  serial_reduce_ctrl_if #(.W(20), .C(4)) ifa ();
  serial_reduce_ctrl_if #(.W(20), .C(6)) ifb ();

  serial_reduce_ctrl #(.W(20), .C(4)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(ifa));
  serial_reduce_ctrl #(.W(20), .C(6)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [2:0]  op;
    logic [19:0] data;
    logic        exp_res;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input int sel, input logic v, input logic [2:0] op,
                       input logic [19:0] d, input logic rdy);
    if (sel == 0) begin
      ifa.i_valid = v; ifa.i_op = op; ifa.i_data = d; ifa.i_ready = rdy;
    end else begin
      ifb.i_valid = v; ifb.i_op = op; ifb.i_data = d; ifb.i_ready = rdy;
    end
  endtask

  task automatic sample(input int sel, output logic v, output logic r,
                        output logic res, output logic [2:0] cyc);
    if (sel == 0) begin
      v = ifa.o_valid; r = ifa.o_ready; res = ifa.o_result; cyc = ifa.o_cycles;
    end else begin
      v = ifb.o_valid; r = ifb.o_ready; res = ifb.o_result; cyc = ifb.o_cycles;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept a request, wait bounded for o_valid; leaves the DUT in DONE.
  task automatic start_and_wait(input vec_t t, output int lat);
    logic v, r, res;
    logic [2:0] cyc;
    sample(t.sel, v, r, res, cyc);
    check({t.name, "_ready_idle"}, {31'd0, r}, 32'd1);
    drive(t.sel, 1'b1, t.op, t.data, 1'b0);
    step();
    drive(t.sel, 1'b0, 3'bxxx, 20'hxxxxx, 1'b0);
    lat = 0;
    sample(t.sel, v, r, res, cyc);
    while (!v && lat < 40) begin
      step();
      lat++;
      sample(t.sel, v, r, res, cyc);
    end
  endtask

  task automatic run_vec(input vec_t t);
    int lat;
    logic v, r, res;
    logic [2:0] cyc;
    start_and_wait(t, lat);
    sample(t.sel, v, r, res, cyc);
    check({t.name, "_latency"}, lat, t.exp_cyc);
    check({t.name, "_result"}, {31'd0, res}, {31'd0, t.exp_res});
    check({t.name, "_cycles"}, {29'd0, cyc}, t.exp_cyc);
    drive(t.sel, 1'b0, 3'd0, 20'd0, 1'b1);
    step();
    drive(t.sel, 1'b0, 3'd0, 20'd0, 1'b0);
    sample(t.sel, v, r, res, cyc);
    check({t.name, "_back_idle"}, {30'd0, v, r}, 32'b01);
  endtask

  initial begin
    logic v, r, res;
    logic [2:0] cyc;
    int lat;
    vec_t t;

    n_pass  = 0;
    n_total = 0;

    vecs[0]  = '{"and_ones",    0, 3'd0, 20'hFFFFF, 1'b1, 5};
    vecs[1]  = '{"xor_7",       0, 3'd2, 20'h00007, 1'b1, 5};
    vecs[2]  = '{"xnor_7",      0, 3'd3, 20'h00007, 1'b0, 5};
    vecs[3]  = '{"not_zero",    0, 3'd5, 20'h00000, 1'b1, 5};
    vecs[4]  = '{"bool_msb",    0, 3'd4, 20'h80000, 1'b1, 5};
    vecs[5]  = '{"and_low0",    0, 3'd0, 20'hFFFF0, 1'b0, EE ? 1 : 5};
    vecs[6]  = '{"or_zero",     0, 3'd1, 20'h00000, 1'b0, 5};
    vecs[7]  = '{"or_chunk1",   0, 3'd1, 20'h00010, 1'b1, EE ? 2 : 5};
    vecs[8]  = '{"xor_ones",    0, 3'd2, 20'hFFFFF, 1'b0, 5};
    vecs[9]  = '{"rsvd6",       0, 3'd6, 20'hFFFFF, 1'b0, 5};
    vecs[10] = '{"rsvd7",       0, 3'd7, 20'h12345, 1'b0, 5};
    vecs[11] = '{"not_chunk2",  0, 3'd5, 20'h00100, 1'b0, EE ? 3 : 5};
    vecs[12] = '{"xnor_zero",   0, 3'd3, 20'h00000, 1'b1, 5};
    vecs[13] = '{"c6_and_ones", 1, 3'd0, 20'hFFFFF, 1'b1, 4};
    vecs[14] = '{"c6_or_zero",  1, 3'd1, 20'h00000, 1'b0, 4};
    vecs[15] = '{"c6_xor_msb",  1, 3'd2, 20'h80000, 1'b1, 4};

    drive(0, 1'b0, 3'd0, 20'd0, 1'b0);
    drive(1, 1'b0, 3'd0, 20'd0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sample(0, v, r, res, cyc);
    check("reset_outputs", {26'd0, v, r, res, cyc}, {26'd0, 1'b0, 1'b1, 1'b0, 3'd0});
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    // Hold DONE with i_ready low while pulsing i_valid with other operands.
    t = '{"hold", 0, 3'd1, 20'h00010, 1'b1, EE ? 2 : 5};
    start_and_wait(t, lat);
    check("hold_latency", lat, t.exp_cyc);
    for (int i = 0; i < 10; i++) begin
      drive(0, i[0], 3'd0, 20'h0000F, 1'b0);
      step();
      sample(0, v, r, res, cyc);
      check("hold_stable", {26'd0, v, r, res, cyc}, {26'd0, 1'b1, 1'b0, 1'b1, 3'(t.exp_cyc)});
    end
    drive(0, 1'b0, 3'd0, 20'd0, 1'b1);
    step();
    drive(0, 1'b0, 3'd0, 20'd0, 1'b0);
    sample(0, v, r, res, cyc);
    check("hold_release", {30'd0, v, r}, 32'b01);
    step();
    sample(0, v, r, res, cyc);
    check("hold_no_latch", {30'd0, v, r}, 32'b01);

    // Reset during RUN after two chunks: outputs clear immediately.
    run_vec(vecs[0]);
    drive(0, 1'b1, 3'd2, 20'h00007, 1'b0);
    step();
    drive(0, 1'b0, 3'd0, 20'd0, 1'b0);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    sample(0, v, r, res, cyc);
    check("midrun_reset", {26'd0, v, r, res, cyc}, {26'd0, 1'b0, 1'b1, 1'b0, 3'd0});
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_vec(vecs[1]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
